// File: rtl/dw_minmax_seq.sv
// Streaming min/max: consumes one word per handshake and reports the winning
// word and its frame position after num_inputs words through a valid/ready port.
module dw_minmax_seq #(
  parameter int unsigned width       = 8,
  parameter int unsigned num_inputs  = 4,
  localparam int unsigned index_width = (num_inputs > 1) ? $clog2(num_inputs) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   tc,
  input  logic                   min_max,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [width-1:0]       a,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [width-1:0]       value,
  output logic [index_width-1:0] index
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t                 state;
  logic [width-1:0]       best;
  logic [index_width-1:0] best_idx;
  logic [index_width-1:0] count;
  logic                   tc_q;
  logic                   min_max_q;
  logic                   gt;
  logic                   lt;
  logic                   better;
  logic                   last;

  // Strict comparison keeps the earlier index on ties.
  always_comb begin
    gt = 1'b0;
    lt = 1'b0;
    if (tc_q) begin
      gt = $signed(a) > $signed(best);
      lt = $signed(a) < $signed(best);
    end else begin
      gt = a > best;
      lt = a < best;
    end
    better = min_max_q ? gt : lt;
  end

  assign last     = (count == index_width'(num_inputs - 1));
  assign in_ready = (state != HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      best      <= '0;
      best_idx  <= '0;
      tc_q      <= 1'b0;
      min_max_q <= 1'b0;
      out_valid <= 1'b0;
      value     <= '0;
      index     <= '0;
    end else if (clr) begin
      // Frame abort: result registers keep their last contents.
      state     <= IDLE;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            best      <= a;
            best_idx  <= '0;
            tc_q      <= tc;
            min_max_q <= min_max;
            if (num_inputs == 1) begin
              value     <= a;
              index     <= '0;
              out_valid <= 1'b1;
              count     <= '0;
              state     <= HOLD;
            end else begin
              count <= index_width'(1);
              state <= ACC;
            end
          end
        end
        ACC: begin
          if (in_valid) begin
            if (better) begin
              best     <= a;
              best_idx <= count;
            end
            count <= count + index_width'(1);
            // Final word: fold the current comparison straight into the result.
            if (last) begin
              value     <= better ? a : best;
              index     <= better ? count : best_idx;
              out_valid <= 1'b1;
              count     <= '0;
              state     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dw_minmax_seq.sv
// Directed bench for dw_minmax_seq: four-word frames plus a single-word instance.
module tb_dw_minmax_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       tc;
  logic       min_max;
  logic [7:0] a;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] value;
  logic [1:0] index;
  logic       in_valid1, in_ready1, out_valid1, out_ready1;
  logic [7:0] value1;
  logic [0:0] index1;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  dw_minmax_seq #(.width(8), .num_inputs(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .tc(tc), .min_max(min_max),
    .in_valid(in_valid), .in_ready(in_ready), .a(a),
    .out_valid(out_valid), .out_ready(out_ready), .value(value), .index(index)
  );

  dw_minmax_seq #(.width(8), .num_inputs(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .tc(tc), .min_max(min_max),
    .in_valid(in_valid1), .in_ready(in_ready1), .a(a),
    .out_valid(out_valid1), .out_ready(out_ready1), .value(value1), .index(index1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one word for a single edge; the block must be ready.
  task automatic send(input logic [7:0] w);
    check("in_ready_before_send", 32'(in_ready), 32'd1);
    a        = w;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] w0, input logic [7:0] w1,
                            input logic [7:0] w2, input logic [7:0] w3);
    send(w0); send(w1); send(w2); send(w3);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; tc = 1'b0; min_max = 1'b0; a = '0;
    in_valid = 1'b0; out_ready = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_value", 32'(value), 32'd0);
    check("rst_index", 32'(index), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Unsigned max: tie on 0xF0 keeps index 1.
    tc = 1'b0; min_max = 1'b1; out_ready = 1'b1;
    send_frame(8'h10, 8'hF0, 8'h7F, 8'hF0);
    check("umax_valid", 32'(out_valid), 32'd1);
    check("umax_value", 32'(value), 32'hF0);
    check("umax_index", 32'(index), 32'd1);
    check("hold_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("umax_drop_valid", 32'(out_valid), 32'd0);
    check("umax_idle_ready", 32'(in_ready), 32'd1);

    // Signed max.
    tc = 1'b1; min_max = 1'b1;
    send_frame(8'h10, 8'hF0, 8'h7F, 8'hF0);
    check("smax_value", 32'(value), 32'h7F);
    check("smax_index", 32'(index), 32'd2);
    tick();

    // Signed min.
    tc = 1'b1; min_max = 1'b0;
    send_frame(8'h10, 8'hF0, 8'h7F, 8'hF0);
    check("smin_value", 32'(value), 32'hF0);
    check("smin_index", 32'(index), 32'd1);
    tick();

    // Gaps between words, then a stalled consumer.
    tc = 1'b0; min_max = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(8'(i + 1));
      if (i < 3) begin
        repeat (3) tick();
        check("gap_no_result", 32'(out_valid), 32'd0);
      end
    end
    a = 8'hFF; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_value", 32'(value), 32'h04);
      check("stall_index", 32'(index), 32'd3);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("stall_release", 32'(out_valid), 32'd0);

    // Mode latched on the first word; mid-frame toggle ignored.
    tc = 1'b0; min_max = 1'b0;
    send(8'd5); send(8'd3);
    min_max = 1'b1;
    send(8'd9); send(8'd1);
    check("latch_value", 32'(value), 32'd1);
    check("latch_index", 32'(index), 32'd3);
    tick();

    // Abort after two words; the word offered with clr is discarded.
    min_max = 1'b0;
    send(8'h50); send(8'h60);
    clr = 1'b1; a = 8'h01; in_valid = 1'b1;
    tick();
    clr = 1'b0; in_valid = 1'b0;
    check("clr_no_valid", 32'(out_valid), 32'd0);
    send(8'd4); send(8'd4); send(8'd4);
    check("clr_not_early", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    send(8'd4);
    check("clr_valid", 32'(out_valid), 32'd1);
    check("clr_value", 32'(value), 32'd4);
    check("clr_index", 32'(index), 32'd0);

    // Asynchronous reset during HOLD.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_value", 32'(value), 32'd0);
    check("arst_index", 32'(index), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    #3;
    rst_n = 1'b1;
    tick();

    // Single-word frames: a result every second cycle.
    a = 8'h22; in_valid1 = 1'b1; out_ready1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("n1_valid", 32'(out_valid1), 32'((i % 2) == 0));
      check("n1_in_ready", 32'(in_ready1), 32'((i % 2) != 0));
      if ((i % 2) == 0) begin
        check("n1_value", 32'(value1), 32'h22);
        check("n1_index", 32'(index1), 32'd0);
      end
    end
    in_valid1 = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dw_minmax_seq.md
Name: dw_minmax_seq

Overview:
- Sequential, streaming counterpart of the team's combinational N-input min/max.
- Accepts one word per handshake and tracks the running minimum or maximum over a frame of num_inputs words.
- Presents the winning value and its position in the frame through a valid/ready output port.
- Used where operands arrive serially from a producer, so no packed item vector is ever assembled.

Parameters:
- width, 8, bits per input word.
- num_inputs, 4, words per frame; legal range 1..256.
- index_width, derived localparam = max(1, ceil(log2(num_inputs))), width of index and of the internal item counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous frame abort.
- tc  input  1  1 = two's-complement compare, 0 = unsigned; sampled with the first word of a frame.
- min_max  input  1  1 = find maximum, 0 = find minimum; sampled with the first word of a frame.
- in_valid  input  1  producer has a word on a.
- in_ready  output  1  block can accept a word.
- a  input  width  input word.
- out_valid  output  1  value/index hold a completed frame result.
- out_ready  input  1  consumer accepts the result.
- value  output  width  winning word, registered.
- index  output  index_width  frame position (0 = first word accepted) of the winning word, registered.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, count=0, out_valid=0, value=0, index=0.
  - Latched tc/min_max cleared to 0.
  - in_ready=1 once reset releases.
- States:
  - IDLE: no word of the current frame accepted yet.
  - ACC: 1..num_inputs-1 words accepted.
  - HOLD: result valid, waiting for the consumer.
- in_ready = (state != HOLD); it is a combinational decode of state only. A word is accepted on a rising edge with in_valid & in_ready.
- Accept in IDLE:
  - best<=a, best_idx<=0.
  - Latch tc and min_max for the whole frame.
  - count<=1, state<=ACC.
  - If num_inputs=1: value<=a, index<=0, out_valid<=1, state<=HOLD in the same edge.
- Accept in ACC:
  - Compare a against best using the latched tc and min_max.
  - Replace best/best_idx (best_idx<=count) only if a is strictly greater (max) or strictly less (min).
  - Ties keep the earlier index: lowest index wins.
  - count<=count+1.
  - On the accept where count==num_inputs-1: load value/index with the final winner, including the current word; out_valid<=1, count<=0, state<=HOLD.
- Latency: out_valid rises on the edge that accepts the last word, so the result is visible in the next cycle.
- Throughput: num_inputs accepted words + at least 1 HOLD cycle per frame.
- HOLD:
  - value/index/out_valid stable until out_valid & out_ready.
  - On that edge: out_valid<=0, state<=IDLE.
  - in_ready=0 throughout HOLD, so no word is accepted in the handshake cycle.
- tc/min_max changes mid-frame are ignored until the next frame's first word.
- in_valid=0 gaps in ACC: state, count and best held, no timeout.
- clr=1 (synchronous):
  - Highest priority: state<=IDLE, count<=0, out_valid<=0.
  - A word presented that cycle is discarded even though in_ready may be 1.
  - value/index keep their last contents.
- Reset mid-frame discards all partial state immediately (asynchronous).
- Signed compare uses width-bit two's complement; no width extension on outputs.

Test Plan:
- width=8, num_inputs=4, tc=0, min_max=1, stream 0x10,0xF0,0x7F,0xF0 back-to-back, out_ready=1 -> out_valid one cycle after 4th accept, value=0xF0, index=1 (tie keeps lower index), returns to IDLE next edge.
- Same stream, tc=1, min_max=1 -> value=0x7F, index=2. Same stream, tc=1, min_max=0 -> value=0xF0, index=1.
- Frame with in_valid gaps of 3 cycles between words, then out_ready held 0 for 5 cycles -> in_ready=0 and value/index stable during HOLD; 5th word offered during HOLD is not accepted.
- tc=0, min_max=0 latched at word 0; toggle min_max=1 at word 2; stream 5,3,9,1 -> value=1, index=3 (minimum mode kept).
- Assert clr after 2 accepted words, then stream 4,4,4,4 -> result value=4, index=0; no trace of the aborted words. Assert rst_n=0 during HOLD -> out_valid drops asynchronously; value=0, index=0.
- num_inputs=1: stream 0x22, out_ready=1 -> each word yields out_valid the next cycle with index=0, one result every 2 cycles.
